// File: rtl/rv_muldiv.sv
// RV32M multiply/divide unit. Iterative shift-and-add multiply and restoring
// divide. States: IDLE waits for start, BUSY iterates, DONE presents x_rd_o.
module rv_muldiv #(
  parameter int g_width              = 32,
  parameter int g_mul_bits_per_cycle = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  input  logic               d_valid_i,
  input  logic               d_is_multiply_i,
  input  logic               d_is_divide_i,
  input  logic [2:0]         d_fun_i,
  input  logic [g_width-1:0] d_rs1_i,
  input  logic [g_width-1:0] d_rs2_i,
  output logic               x_stall_req_o,
  output logic [g_width-1:0] x_rd_o
);

  localparam int W  = g_width;
  localparam int B  = g_mul_bits_per_cycle;
  localparam int CW = $clog2(g_width) + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [1:0]      fun_q, fun_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    rd_q, rd_d;

  logic            start, s1, s2, sgn_div;
  logic [W-1:0]    abs1, abs2, op_a, op_b;
  logic            op_neg;
  logic [W+B-1:0]  pp, msum;
  logic [2*W+B-1:0] mcat;
  logic [2*W-1:0]  mul_next, div_next, step_acc, prod_fin;
  logic [W:0]      dtrial;
  logic [W-1:0]    dres, result;

  assign start = (state_q == IDLE) && d_valid_i && (d_is_multiply_i || d_is_divide_i) && !x_kill_i;
  assign s1    = d_rs1_i[W-1];
  assign s2    = d_rs2_i[W-1];
  assign abs1  = s1 ? -d_rs1_i : d_rs1_i;
  assign abs2  = s2 ? -d_rs2_i : d_rs2_i;
  assign sgn_div = !d_fun_i[0];

  // Magnitudes and result sign; MUL low half is sign-agnostic so runs unsigned.
  always_comb begin
    op_a   = d_rs1_i;
    op_b   = d_rs2_i;
    op_neg = 1'b0;
    if (d_is_divide_i) begin
      if (sgn_div) begin
        op_a   = abs1;
        op_b   = abs2;
        op_neg = d_fun_i[1] ? s1 : (s1 ^ s2);
      end
    end else begin
      case (d_fun_i[1:0])
        2'b01: begin op_a = abs1; op_b = abs2; op_neg = s1 ^ s2; end
        2'b10: begin op_a = abs1; op_neg = s1; end
        default: ;
      endcase
    end
  end

  // Multiply step: add digit partial product into the high half, shift right by B.
  assign pp       = {{B{1'b0}}, mcand_q} * {{W{1'b0}}, mplier_q[B-1:0]};
  assign msum     = {{B{1'b0}}, acc_q[2*W-1:W]} + pp;
  assign mcat     = {msum, acc_q[W-1:0]};
  assign mul_next = (2*W)'(mcat >> B);

  // Divide step: acc holds {remainder, dividend/quotient}.
  assign dtrial   = acc_q[2*W-1:W-1] - {1'b0, mcand_q};
  assign div_next = dtrial[W] ? {acc_q[2*W-2:0], 1'b0}
                              : {dtrial[W-1:0], acc_q[W-2:0], 1'b1};

  assign step_acc = is_div_q ? div_next : mul_next;
  assign prod_fin = neg_q ? -step_acc : step_acc;
  assign dres     = fun_q[1] ? step_acc[2*W-1:W] : step_acc[W-1:0];

  always_comb begin
    result = '0;
    if (is_div_q) result = neg_q ? -dres : dres;
    else if (fun_q == 2'b00) result = prod_fin[W-1:0];
    else result = prod_fin[2*W-1:W];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    fun_d         = fun_q;
    is_div_d      = is_div_q;
    neg_d         = neg_q;
    rd_d          = rd_q;
    x_stall_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_stall_req_o = 1'b1;
          fun_d    = d_fun_i[1:0];
          is_div_d = d_is_divide_i;
          neg_d    = op_neg;
          mcand_d  = d_is_divide_i ? op_b : op_a;
          mplier_d = op_b;
          acc_d    = d_is_divide_i ? {{W{1'b0}}, op_a} : '0;
          cnt_d    = d_is_divide_i ? CW'(W) : CW'(W / B);
          state_d  = BUSY;
          if (d_is_divide_i && d_rs2_i == '0) begin
            rd_d    = d_fun_i[1] ? d_rs1_i : '1;
            cnt_d   = '0;
            state_d = DONE;
          end else if (d_is_divide_i && sgn_div && d_rs1_i == MIN_NEG && d_rs2_i == '1) begin
            rd_d    = d_fun_i[1] ? '0 : d_rs1_i;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        x_stall_req_o = 1'b1;
        acc_d    = step_acc;
        mplier_d = mplier_q >> B;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rd_d    = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!x_stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (x_kill_i) begin
      x_stall_req_o = 1'b0;
      state_d       = IDLE;
      cnt_d         = '0;
      rd_d          = rd_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      fun_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      fun_q    <= fun_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
    end
  end

  assign x_rd_o = rd_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Directed-vector bench for rv_muldiv: table of operations plus hand-written
// kill, stall-hold and reset sequences.
module tb_rv_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_stall_i;
  logic        x_kill_i;
  logic        d_valid_i;
  logic        d_is_multiply_i;
  logic        d_is_divide_i;
  logic [2:0]  d_fun_i;
  logic [31:0] d_rs1_i;
  logic [31:0] d_rs2_i;
  logic        x_stall_req_o;
  logic [31:0] x_rd_o;

  int n_cmp = 0;
  int n_bad = 0;

  rv_muldiv #(.g_width(32), .g_mul_bits_per_cycle(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .x_stall_i(x_stall_i), .x_kill_i(x_kill_i),
    .d_valid_i(d_valid_i), .d_is_multiply_i(d_is_multiply_i),
    .d_is_divide_i(d_is_divide_i), .d_fun_i(d_fun_i), .d_rs1_i(d_rs1_i),
    .d_rs2_i(d_rs2_i), .x_stall_req_o(x_stall_req_o), .x_rd_o(x_rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        is_div;
    logic [2:0]  fun;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    d_valid_i       = 1'b0;
    d_is_multiply_i = 1'b0;
    d_is_divide_i   = 1'b0;
  endtask

  task automatic drive_op(input logic div, input logic [2:0] fun,
                          input logic [31:0] a, input logic [31:0] b);
    d_valid_i       = 1'b1;
    d_is_multiply_i = !div;
    d_is_divide_i   = div;
    d_fun_i         = fun;
    d_rs1_i         = a;
    d_rs2_i         = b;
  endtask

  // Issues one op and counts cycles with x_stall_req_o high; returns in DONE.
  task automatic run_op(input logic div, input logic [2:0] fun,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rd, output int stalls);
    bit fin;
    fin    = 1'b0;
    stalls = 0;
    @(negedge clk_i);
    drive_op(div, fun, a, b);
    for (int c = 0; c < 100 && !fin; c++) begin
      #1;
      if (x_stall_req_o) begin
        stalls++;
        @(posedge clk_i);
        #1;
        drive_idle();
        @(negedge clk_i);
      end else begin
        fin = 1'b1;
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: stall still high after %0d cycles, expected release", stalls);
    end
    drive_idle();
    rd = x_rd_o;
  endtask

  vec_t vecs[16];
  logic [31:0] rd;
  int stalls;

  initial begin
    vecs[0]  = '{"mul_7_neg3",     1'b0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 17};
    vecs[1]  = '{"mulh_min_min",   1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 17};
    vecs[2]  = '{"mulhu_ones",     1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 17};
    vecs[3]  = '{"mulhsu_ones",    1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 17};
    vecs[4]  = '{"div_neg7_2",     1'b1, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{"rem_neg7_2",     1'b1, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{"divu_100_7",     1'b1, 3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{"remu_100_7",     1'b1, 3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{"div_by_zero",    1'b1, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{"remu_by_zero",   1'b1, 3'b111, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{"div_overflow",   1'b1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{"rem_overflow",   1'b1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{"mulh_neg3_5",    1'b0, 3'b001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 17};
    vecs[13] = '{"mul_shift",      1'b0, 3'b000, 32'h12345678, 32'h10,       32'h23456780, 17};
    vecs[14] = '{"div_7_neg2",     1'b1, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[15] = '{"rem_7_neg2",     1'b1, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};

    rst_i = 1'b1; x_stall_i = 1'b0; x_kill_i = 1'b0;
    d_fun_i = 3'b000; d_rs1_i = '0; d_rs2_i = '0;
    drive_idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("reset_rd", x_rd_o, 32'd0);
    chk("reset_stall", {31'd0, x_stall_req_o}, 32'd0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].is_div, vecs[i].fun, vecs[i].rs1, vecs[i].rs2, rd, stalls);
      chk({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_stalls"}, 32'(stalls), 32'(vecs[i].exp_stall));
    end

    // Kill on the 5th BUSY cycle; previous result (rem_7_neg2 = 1) must survive.
    @(negedge clk_i);
    drive_op(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk_i);
    #1;
    drive_idle();
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    x_kill_i = 1'b1;
    #1;
    chk("kill_stall_same_cycle", {31'd0, x_stall_req_o}, 32'd0);
    @(posedge clk_i);
    #1;
    x_kill_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("kill_idle_stall", {31'd0, x_stall_req_o}, 32'd0);
    chk("kill_rd_kept", x_rd_o, 32'd1);
    run_op(1'b0, 3'b000, 32'd3, 32'd4, rd, stalls);
    chk("after_kill_mul_rd", rd, 32'd12);
    chk("after_kill_mul_stalls", 32'(stalls), 32'd17);

    // Kill and start in the same cycle: kill wins.
    @(negedge clk_i);
    drive_op(1'b0, 3'b000, 32'd5, 32'd6);
    x_kill_i = 1'b1;
    #1;
    chk("kill_start_stall", {31'd0, x_stall_req_o}, 32'd0);
    @(posedge clk_i);
    #1;
    x_kill_i = 1'b0;
    drive_idle();
    @(negedge clk_i);
    #1;
    chk("kill_start_no_busy", {31'd0, x_stall_req_o}, 32'd0);
    chk("kill_start_rd", x_rd_o, 32'd12);

    // Hold DONE with x_stall_i while a new request is offered.
    x_stall_i = 1'b1;
    run_op(1'b1, 3'b101, 32'd100, 32'd7, rd, stalls);
    chk("hold_divu_rd", rd, 32'd14);
    chk("hold_divu_stalls", 32'(stalls), 32'd33);
    drive_op(1'b0, 3'b000, 32'd9, 32'd9);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk($sformatf("hold_rd_%0d", k), x_rd_o, 32'd14);
      chk($sformatf("hold_no_restart_%0d", k), {31'd0, x_stall_req_o}, 32'd0);
    end
    drive_idle();
    x_stall_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("hold_release_stall", {31'd0, x_stall_req_o}, 32'd0);
    chk("idle_keeps_rd", x_rd_o, 32'd14);

    // Reset in the middle of a divide.
    @(negedge clk_i);
    drive_op(1'b1, 3'b101, 32'd1000, 32'd3);
    @(posedge clk_i);
    #1;
    drive_idle();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midbusy_reset_rd", x_rd_o, 32'd0);
    chk("midbusy_reset_stall", {31'd0, x_stall_req_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op(1'b0, 3'b000, 32'd3, 32'd4, rd, stalls);
    chk("after_reset_mul_rd", rd, 32'd12);
    chk("after_reset_mul_stalls", 32'(stalls), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
